// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, check 11-bit frames,
// decode E0/F0 prefixes into key events, buffer them in a FWFT FIFO and drive a strobe.
module ps2_key_event_rx #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned STROBE_CYCLES  = 10000000,
  parameter int unsigned EMIT_MAKE      = 0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_break,
  output logic       strobe_out,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SCW = $clog2(STROBE_CYCLES + 1);

  // ---------------- input conditioning ----------------
  logic [1:0]     clk_sync;
  logic [1:0]     dat_sync;
  logic           clk_filt;
  logic [FCW-1:0] flt_cnt;
  logic           fall;
  logic           clk_s;
  logic           dat_s;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // fall is raised in the same cycle the filtered level drops to 0
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FCW'(FILTER_CYCLES - 1)) begin
        clk_filt <= clk_s;
        flt_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state, state_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_bit, par_n;
  logic           done_n, err_n;
  logic           byte_done;
  logic [TCW-1:0] to_cnt;
  logic           timeout;

  assign timeout = (state != S_IDLE) && (to_cnt == TCW'(TIMEOUT_CYCLES));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      byte_done <= done_n;
      frame_err <= err_n;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall || state == S_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TCW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    done_n    = 1'b0;
    err_n     = 1'b0;
    if (timeout) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else if (fall) begin
      unique case (state)
        S_IDLE: begin
          if (!dat_s) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end
        end
        S_DATA: begin
          shreg_n   = {dat_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_n   = dat_s;
          state_n = S_STOP;
        end
        S_STOP: begin
          if (dat_s && (^{shreg, par_bit})) done_n = 1'b1;
          else                              err_n  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ---------------- prefix decoder ----------------
  logic       ext_f;
  logic       brk_f;
  logic       push;
  logic [9:0] push_data;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (frame_err) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_done) begin
        if (shreg == 8'hE0) begin
          ext_f <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_f <= 1'b1;
        end else begin
          ext_f     <= 1'b0;
          brk_f     <= 1'b0;
          push      <= brk_f || (EMIT_MAKE != 0);
          push_data <= {ext_f, brk_f, shreg};
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic [9:0]  head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && event_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign overflow    = push && full && !pop;
  assign event_valid = !empty;
  assign event_ext   = empty ? 1'b0 : head[9];
  assign event_break = empty ? 1'b0 : head[8];
  assign event_code  = empty ? 8'h00 : head[7:0];

  // ---------------- indicator strobe ----------------
  logic [SCW-1:0] stb_cnt, stb_cnt_n;

  always_comb begin
    stb_cnt_n = stb_cnt;
    if (push_ok)             stb_cnt_n = SCW'(STROBE_CYCLES);
    else if (stb_cnt != '0)  stb_cnt_n = stb_cnt - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_cnt    <= '0;
      strobe_out <= 1'b0;
    end else begin
      stb_cnt    <= stb_cnt_n;
      strobe_out <= (stb_cnt_n != '0);
    end
  end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench: two receivers (release-only and press+release) share the PS/2 lines;
// expected events are queued at stimulus time and popped by per-instance monitors.
module tb_ps2_key_event_rx;

  localparam int unsigned STROBE = 50;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic event_ready = 1'b1;

  logic       v0, x0, b0, s0, e0, o0;
  logic [7:0] c0;
  logic       v1, x1, b1, s1, e1, o1;
  logic [7:0] c1;

  always #5 sys_clk = ~sys_clk;

  ps2_key_event_rx #(
    .FIFO_DEPTH(4), .FILTER_CYCLES(4), .TIMEOUT_CYCLES(300),
    .STROBE_CYCLES(STROBE), .EMIT_MAKE(0)
  ) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .event_ready(event_ready), .event_valid(v0), .event_code(c0), .event_ext(x0),
    .event_break(b0), .strobe_out(s0), .frame_err(e0), .overflow(o0)
  );

  ps2_key_event_rx #(
    .FIFO_DEPTH(4), .FILTER_CYCLES(4), .TIMEOUT_CYCLES(300),
    .STROBE_CYCLES(STROBE), .EMIT_MAKE(1)
  ) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .event_ready(event_ready), .event_valid(v1), .event_code(c1), .event_ext(x1),
    .event_break(b1), .strobe_out(s1), .frame_err(e1), .overflow(o1)
  );

  int checks = 0;
  int failures = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int err0 = 0, err1 = 0, ovf0 = 0, ovf1 = 0, stb0 = 0, stb1 = 0;
  int exp_err = 0, exp_ovf = 0, exp_stb0 = 0, exp_stb1 = 0;
  int er0 = 0, or0 = 0, sr0 = 0, er1 = 0, or1 = 0, sr1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge sys_clk) begin
    if (rst_n && v0 && event_ready) begin
      if (q0.size() == 0) check("dut0_unexpected_event", {22'd0, x0, b0, c0}, 32'hFFFF_FFFF);
      else                check("dut0_event", {22'd0, x0, b0, c0}, {22'd0, q0.pop_front()});
    end
    if (rst_n && v1 && event_ready) begin
      if (q1.size() == 0) check("dut1_unexpected_event", {22'd0, x1, b1, c1}, 32'hFFFF_FFFF);
      else                check("dut1_event", {22'd0, x1, b1, c1}, {22'd0, q1.pop_front()});
    end
  end

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      er0 = 0; or0 = 0; sr0 = 0; er1 = 0; or1 = 0; sr1 = 0;
    end else begin
      if (e0) er0++;
      else if (er0 != 0) begin err0++; check("dut0_frame_err_width", er0, 1); er0 = 0; end
      if (o0) or0++;
      else if (or0 != 0) begin ovf0++; check("dut0_overflow_width", or0, 1); or0 = 0; end
      if (s0) sr0++;
      else if (sr0 != 0) begin stb0++; check("dut0_strobe_len", sr0, STROBE); sr0 = 0; end
      if (e1) er1++;
      else if (er1 != 0) begin err1++; check("dut1_frame_err_width", er1, 1); er1 = 0; end
      if (o1) or1++;
      else if (or1 != 0) begin ovf1++; check("dut1_overflow_width", or1, 1); or1 = 0; end
      if (s1) sr1++;
      else if (sr1 != 0) begin stb1++; check("dut1_strobe_len", sr1, STROBE); sr1 = 0; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(6);
    ps2_clk = 1'b0;
    cyc(12);
    ps2_clk = 1'b1;
    cyc(6);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    cyc(30);
  endtask

  // release-only instance sees only break events
  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    q1.push_back({ext, brk, code});
    exp_stb1++;
    if (brk) begin
      q0.push_back({ext, brk, code});
      exp_stb0++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      cyc(1);
      n++;
    end
    check(name, q0.size() + q1.size(), 0);
    cyc(5);
  endtask

  task automatic check_counts(input string name);
    check({name, "_err0"}, err0, exp_err);
    check({name, "_err1"}, err1, exp_err);
  endtask

  task automatic check_zero(input string name);
    check({name, "_dut0"}, {18'd0, v0, c0, x0, b0, s0, e0, o0}, 0);
    check({name, "_dut1"}, {18'd0, v1, c1, x1, b1, s1, e1, o1}, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(5);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    cyc(20);

    // release of 1C; make only on the press+release instance
    expect_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 0);
    expect_ev(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain("t1_drain");
    check_counts("t1");

    // extended key press and release
    expect_ev(1'b1, 1'b0, 8'h75);
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    expect_ev(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    drain("t2_drain");
    check_counts("t2");

    // bad parity frame is rejected, decoding resumes
    send_frame(8'h1C, 1);
    exp_err++;
    expect_ev(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain("t3_drain");
    check_counts("t3");

    // overflow: 4 accepted, 5th dropped
    event_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_ev(1'b0, 1'b1, 8'(k));
      send_frame(8'hF0, 0);
      send_frame(8'(k), 0);
    end
    exp_ovf++;
    cyc(10);
    check("t4_ovf0", ovf0, exp_ovf);
    check("t4_ovf1", ovf1, exp_ovf);
    check("t4_valid_held", {30'd0, v0, v1}, 32'h3);
    event_ready = 1'b1;
    drain("t4_drain");
    check("t4_valid_fell", {30'd0, v0, v1}, 0);

    // timeout mid-frame clears the pending F0
    send_frame(8'hF0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    cyc(400);
    exp_err++;
    check_counts("t5_timeout");
    expect_ev(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 0);
    expect_ev(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain("t5_drain");

    // reset mid-frame
    cyc(100);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    check_zero("t6_reset_outputs");
    rst_n = 1'b1;
    cyc(20);
    expect_ev(1'b0, 1'b1, 8'h1C);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain("t6_drain");
    check_counts("t6");

    // short clock glitch in idle with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(40);
    expect_ev(1'b0, 1'b1, 8'h5A);
    send_frame(8'hF0, 0);
    send_frame(8'h5A, 0);
    drain("t7_drain");
    check_counts("t7");

    cyc(STROBE + 10);
    check("final_ovf0", ovf0, exp_ovf);
    check("final_ovf1", ovf1, exp_ovf);
    check("final_strobes0", stb0, exp_stb0);
    check("final_strobes1", stb1, exp_stb1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver. It oversamples `ps2_clk`/`ps2_data` in the `sys_clk` domain, checks every 11-bit frame, and decodes E0/F0 prefix sequences into key events. Events are buffered in a FIFO behind a valid/ready handshake and drive a retriggerable indicator strobe. It sits between the PS/2 pins and the game logic, and is the next generation of the keyboard input path. Over the previous design it adds a single clock domain, frame checking, extended keys, optional make events, buffering and reset.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event FIFO entries; power of 2, ≥2.
- `FILTER_CYCLES`, default 8: consecutive equal samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYCLES`, default 200000: idle `sys_clk` cycles allowed mid-frame before abort.
- `STROBE_CYCLES`, default 10000000: strobe length in `sys_clk` cycles (100 ms at 100 MHz).
- `EMIT_MAKE`, default 0: 0 = release events only; 1 = press and release events.

Ports:
- `sys_clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `event_ready`  in  1  consumer pops the head entry when `event_valid` is also high.
- `event_valid`  out  1  FIFO not empty.
- `event_code`  out  8  scancode of the head entry.
- `event_ext`  out  1  head entry was E0-prefixed.
- `event_break`  out  1  head entry is a release.
- `strobe_out`  out  1  event indicator.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.
- `overflow`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Reset** (async, `rst_n`=0):
  - all outputs 0, FIFO empty, strobe counter 0.
  - frame FSM in IDLE, prefix flags clear.
  - synchroniser and filter state forced to 1 (idle bus).
- **Input conditioning:** 2-FF synchroniser on each input. The filter counter resets whenever the sample equals the filtered level; the filtered level toggles when the counter reaches `FILTER_CYCLES`-1. A falling edge of filtered `ps2_clk` produces a one-cycle `fall` strobe. Data is sampled from the synchronised `ps2_data` on `fall`.
- **Frame FSM** (advances only on `fall`):
  - IDLE: data=0 → DATA with bit count 0; data=1 → stay in IDLE, no error.
  - DATA: shift bits in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop=1 and the 8 data bits plus the parity bit have an odd number of ones → `byte_done`; otherwise `frame_err`. Either way → IDLE.
  - Timeout: a counter reloads on every `fall`. If it reaches `TIMEOUT_CYCLES` while not in IDLE, the FSM returns to IDLE, pulses `frame_err`, and clears the prefix flags.
  - Any `frame_err` clears the prefix flags.
- **Decoder** (on `byte_done`):
  - E0 → set ext.
  - F0 → set brk.
  - Any other byte: form an event {ext, brk, byte} and clear both flags. If brk=0 and `EMIT_MAKE`=0, the event is discarded.
- **FIFO:**
  - First-word fall-through; outputs are the head entry and are 0 when empty.
  - Pop when `event_valid && event_ready`.
  - A push when full with no pop in the same cycle is dropped and pulses `overflow`.
  - Full with a simultaneous pop: the push is accepted.
  - Order is strictly preserved.
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits and wrap modulo 2·`FIFO_DEPTH`.
- **Strobe:** every accepted push loads the counter with `STROBE_CYCLES`, retriggering if already running. The counter decrements to 0 and `strobe_out` = (counter ≠ 0), registered. Dropped events do not retrigger the strobe.

## Timing
- Cycle E is the cycle in which `fall` for the stop bit is high.
- E+1: `byte_done` or `frame_err` registered; `frame_err` is high for exactly cycle E+1.
- E+2: event pushed; `overflow` pulses in E+2 if the push is dropped.
- E+3: `event_valid`=1 (from empty) and `strobe_out`=1.
- `strobe_out` stays high for exactly `STROBE_CYCLES` cycles after the last accepted push.
- Pop is visible next cycle: the head entry advances, or `event_valid` falls if the FIFO is now empty.
- Pin edge to `fall`: 2 synchroniser cycles plus `FILTER_CYCLES` cycles.
- `rst_n` asserted mid-frame or mid-strobe: immediate abort, no event, no pulse. The first complete frame after release decodes normally.

## Test plan
- **Release of 0x1C** (`EMIT_MAKE`=0): send frames 1C, F0, 1C → exactly one event {code=1C, ext=0, break=1}; `strobe_out` high for `STROBE_CYCLES`; no `frame_err`.
- **Extended key, press and release** (`EMIT_MAKE`=1): send E0 75 E0 F0 75 → events {75, ext=1, break=0} then {75, ext=1, break=1}.
- **Bad parity:** frame 1C with even parity, then F0 1C → one `frame_err` pulse at E+1. The first 1C yields nothing; the following F0 1C still yields release 1C.
- **Overflow** (`FIFO_DEPTH`=4, `event_ready`=0): send 5 releases of 0x01–0x05 → one `overflow` pulse on the 5th. Then with ready=1, pops return 01, 02, 03, 04 and `event_valid` falls.
- **Timeout and reset:** stop `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES` → `frame_err` pulse and FSM back in IDLE; a following good frame decodes. Separately, assert `rst_n` mid-frame → outputs 0; the next F0 1C decodes.
- **Glitch:** a `ps2_clk` low pulse shorter than `FILTER_CYCLES` cycles in IDLE → no bit sampled and no error.
